// File: rtl/winner_judge_pkg.sv
// ----------------------------------------------------------------------------
// winner_judge_pkg : shared game state encoding and winner result codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package winner_judge_pkg;

  typedef enum logic [1:0] {
    ST_START    = 2'b00,
    ST_GAME     = 2'b01,
    ST_GAMEOVER = 2'b10
  } game_state_e;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_LOCAL  = 2'b01;
  localparam logic [1:0] WIN_REMOTE = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/winner_judge_frame_downcounter.sv
// ----------------------------------------------------------------------------
// frame_downcounter : loadable frame counter, expire flags the tick at count 1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_downcounter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = en && tick && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/winner_judge.sv
// ----------------------------------------------------------------------------
// winner_judge : turns per-player hit flags into a one-shot winner report
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module winner_judge
  import winner_judge_pkg::*;
#(
  parameter int SPAWN_FRAMES = 60,
  parameter int GRACE_FRAMES = 3,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_rst,
  input  logic [1:0] state,
  input  logic       frame_tick,
  input  logic       local_hit,
  input  logic       remote_hit,
  output logic       winner_valid,
  output logic [1:0] winner_code
);

  typedef enum logic [2:0] {
    J_IDLE   = 3'd0,
    J_SPAWN  = 3'd1,
    J_ARMED  = 3'd2,
    J_GRACE  = 3'd3,
    J_REPORT = 3'd4,
    J_DONE   = 3'd5
  } judge_e;

  judge_e     fsm;
  logic       local_dead;
  logic       remote_dead;
  logic       in_game;
  logic       eff_local;
  logic       eff_remote;
  logic       both_dead;
  logic       one_dead;
  logic [1:0] survivor_code;
  logic       spawn_expire;
  logic       grace_expire;
  logic       grace_load;

  assign in_game       = (state == ST_GAME);
  assign eff_local     = local_dead | local_hit;
  assign eff_remote    = remote_dead | remote_hit;
  assign both_dead     = eff_local & eff_remote;
  assign one_dead      = eff_local ^ eff_remote;
  assign survivor_code = eff_local ? WIN_REMOTE : WIN_LOCAL;
  assign grace_load    = (fsm == J_ARMED) && frame_tick && in_game && one_dead && !game_rst;

  frame_downcounter #(.CNT_W(CNT_W)) u_spawn_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (game_rst),
    .load_val (CNT_W'(SPAWN_FRAMES)),
    .tick     (frame_tick),
    .en       (fsm == J_SPAWN),
    .expire   (spawn_expire)
  );

  frame_downcounter #(.CNT_W(CNT_W)) u_grace_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (game_rst),
    .load     (grace_load),
    .load_val (CNT_W'(GRACE_FRAMES)),
    .tick     (frame_tick),
    .en       (fsm == J_GRACE),
    .expire   (grace_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= J_IDLE;
      local_dead   <= 1'b0;
      remote_dead  <= 1'b0;
      winner_valid <= 1'b0;
      winner_code  <= WIN_NONE;
    end else if (game_rst) begin
      fsm          <= (SPAWN_FRAMES == 0) ? J_ARMED : J_SPAWN;
      local_dead   <= 1'b0;
      remote_dead  <= 1'b0;
      winner_valid <= 1'b0;
      winner_code  <= WIN_NONE;
    end else begin
      winner_valid <= 1'b0;
      // Leaving GAME mid-round abandons judging without a result.
      if (!in_game && (fsm == J_SPAWN || fsm == J_ARMED || fsm == J_GRACE)) begin
        fsm <= J_IDLE;
      end else begin
        case (fsm)
          J_SPAWN: begin
            if (spawn_expire) fsm <= J_ARMED;
          end
          J_ARMED: begin
            local_dead  <= eff_local;
            remote_dead <= eff_remote;
            if (frame_tick) begin
              if (both_dead) begin
                fsm          <= J_REPORT;
                winner_valid <= 1'b1;
                winner_code  <= WIN_DRAW;
              end else if (one_dead) begin
                if (GRACE_FRAMES == 0) begin
                  fsm          <= J_REPORT;
                  winner_valid <= 1'b1;
                  winner_code  <= survivor_code;
                end else begin
                  fsm <= J_GRACE;
                end
              end
            end
          end
          J_GRACE: begin
            local_dead  <= eff_local;
            remote_dead <= eff_remote;
            if (frame_tick) begin
              if (both_dead) begin
                fsm          <= J_REPORT;
                winner_valid <= 1'b1;
                winner_code  <= WIN_DRAW;
              end else if (grace_expire) begin
                fsm          <= J_REPORT;
                winner_valid <= 1'b1;
                winner_code  <= survivor_code;
              end
            end
          end
          J_REPORT: fsm <= J_DONE;
          default:  fsm <= fsm;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_winner_judge.sv
// ----------------------------------------------------------------------------
// tb_winner_judge : bench for winner_judge (default build and a no-spawn/no-grace build)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_winner_judge;
  import winner_judge_pkg::*;

  logic       clk = 1'b0;
  logic       rst, game_rst, frame_tick, local_hit, remote_hit;
  logic [1:0] state;
  logic       wv_a, wv_b;
  logic [1:0] wc_a, wc_b;
  logic       last_v;
  logic [1:0] last_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  winner_judge #(.SPAWN_FRAMES(60), .GRACE_FRAMES(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .game_rst(game_rst), .state(state), .frame_tick(frame_tick),
    .local_hit(local_hit), .remote_hit(remote_hit), .winner_valid(wv_a), .winner_code(wc_a)
  );

  winner_judge #(.SPAWN_FRAMES(0), .GRACE_FRAMES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .game_rst(game_rst), .state(state), .frame_tick(frame_tick),
    .local_hit(local_hit), .remote_hit(remote_hit), .winner_valid(wv_b), .winner_code(wc_b)
  );

  // Reference: frames of immunity left, frames of grace left (-1 = nobody dead yet)
  typedef struct {
    bit         active;
    bit         decided;
    int         immune;
    int         grace;
    bit         ld;
    bit         rd;
    bit         valid;
    logic [1:0] code;
  } ref_t;

  ref_t ma, mb;

  function automatic ref_t ref_step(ref_t m_in, int sp, int gr);
    ref_t m = m_in;
    bit el, er;
    m.valid = 1'b0;
    if (rst) begin
      m = '{default: 0};
    end else if (game_rst) begin
      m = '{default: 0};
      m.active = 1'b1;
      m.immune = sp;
      m.grace  = -1;
    end else if (m.active && !m.decided) begin
      if (state != 2'b01) begin
        m.active = 1'b0;
      end else if (m.immune > 0) begin
        if (frame_tick) m.immune--;
      end else begin
        el = m.ld | local_hit;
        er = m.rd | remote_hit;
        m.ld = el;
        m.rd = er;
        if (frame_tick) begin
          if (el && er) begin
            m.decided = 1'b1; m.valid = 1'b1; m.code = 2'b11;
          end else if (m.grace < 0) begin
            if (el || er) begin
              if (gr == 0) begin
                m.decided = 1'b1; m.valid = 1'b1; m.code = el ? 2'b10 : 2'b01;
              end else begin
                m.grace = gr;
              end
            end
          end else begin
            m.grace--;
            if (m.grace == 0) begin
              m.decided = 1'b1; m.valid = 1'b1; m.code = el ? 2'b10 : 2'b01;
            end
          end
        end
      end
    end
    return m;
  endfunction

  task automatic check(string name, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got valid/code=%b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = ref_step(ma, 60, 3);
    mb = ref_step(mb, 0, 0);
    #1;
    check("model_a", {wv_a, wc_a}, {ma.valid, ma.code});
    check("model_b", {wv_b, wc_b}, {mb.valid, mb.code});
  endtask

  task automatic drive(logic r, logic g, logic [1:0] s, logic t, logic l, logic h);
    rst = r; game_rst = g; state = s; frame_tick = t; local_hit = l; remote_hit = h;
  endtask

  // One frame: tick cycle (result captured), then two quiet cycles; hits held throughout
  task automatic frame(logic l, logic h);
    drive(1'b0, 1'b0, 2'b01, 1'b1, l, h);
    cycle();
    last_v = wv_a;
    last_c = wc_a;
    frame_tick = 1'b0;
    cycle();
    cycle();
    local_hit = 1'b0;
    remote_hit = 1'b0;
  endtask

  task automatic restart();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle();
    game_rst = 1'b0;
  endtask

  task automatic arm();
    restart();
    for (int i = 0; i < 60; i++) frame(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       r, g;
    logic [1:0] s;
    logic       t, l, h;
    logic       ev;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[16];
  int   pulses;

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Vectors for the SPAWN_FRAMES=0 / GRACE_FRAMES=0 build
    vecs[0]  = '{1, 0, 2'b01, 0, 0, 0, 0, 2'b00};
    vecs[1]  = '{0, 1, 2'b01, 0, 0, 0, 0, 2'b00};
    vecs[2]  = '{0, 0, 2'b01, 1, 0, 0, 0, 2'b00};
    vecs[3]  = '{0, 0, 2'b01, 0, 0, 1, 0, 2'b00};
    vecs[4]  = '{0, 0, 2'b01, 1, 0, 0, 1, 2'b01};
    vecs[5]  = '{0, 0, 2'b01, 0, 0, 0, 0, 2'b01};
    vecs[6]  = '{0, 0, 2'b01, 1, 1, 1, 0, 2'b01};
    vecs[7]  = '{0, 1, 2'b01, 0, 0, 0, 0, 2'b00};
    vecs[8]  = '{0, 0, 2'b01, 1, 1, 1, 1, 2'b11};
    vecs[9]  = '{0, 0, 2'b01, 0, 0, 0, 0, 2'b11};
    vecs[10] = '{0, 1, 2'b01, 1, 1, 0, 0, 2'b00};
    vecs[11] = '{0, 0, 2'b01, 1, 0, 0, 0, 2'b00};
    vecs[12] = '{0, 0, 2'b00, 0, 1, 0, 0, 2'b00};
    vecs[13] = '{0, 0, 2'b01, 1, 1, 0, 0, 2'b00};
    vecs[14] = '{0, 1, 2'b01, 0, 0, 0, 0, 2'b00};
    vecs[15] = '{0, 0, 2'b01, 1, 1, 0, 1, 2'b10};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r, vecs[i].g, vecs[i].s, vecs[i].t, vecs[i].l, vecs[i].h);
      cycle();
      check($sformatf("vec%0d", i), {wv_b, wc_b}, {vecs[i].ev, vecs[i].ec});
    end

    // Spawn immunity, then local death -> remote wins after three grace ticks
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle();
    check("reset", {wv_a, wc_a}, {1'b0, WIN_NONE});
    restart();
    pulses = 0;
    for (int i = 0; i < 59; i++) begin
      frame(1'b1, 1'b0);
      pulses += int'(last_v);
    end
    frame(1'b0, 1'b0);
    pulses += int'(last_v);
    check("spawn_no_pulse", {pulses != 0, wc_a}, {1'b0, WIN_NONE});
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("grace_pending", {last_v, last_c}, {1'b0, WIN_NONE});
    frame(1'b0, 1'b0);
    check("spawn_report", {last_v, last_c}, {1'b1, WIN_REMOTE});

    // Draw: second death arrives between grace ticks
    arm();
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    cycle();
    remote_hit = 1'b0;
    frame(1'b0, 1'b0);
    check("grace_draw", {last_v, last_c}, {1'b1, WIN_DRAW});

    // Simultaneous hits on the tick
    arm();
    frame(1'b1, 1'b1);
    check("simul_draw", {last_v, last_c}, {1'b1, WIN_DRAW});

    // Abort from GRACE
    arm();
    frame(1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cycle();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 1'b1);
      pulses += int'(last_v);
    end
    check("abort", {pulses != 0, wc_a}, {1'b0, WIN_NONE});

    // game_rst on the deciding tick wins; spawn immunity restarts
    arm();
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    cycle();
    check("grst_override", {wv_a, wc_a}, {1'b0, WIN_NONE});
    frame(1'b1, 1'b1);
    check("respawn_immune", {last_v, last_c}, {1'b0, WIN_NONE});

    // Remote death after re-spawn -> local wins; then hold and single pulse
    for (int i = 0; i < 59; i++) frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("local_wins", {last_v, last_c}, {1'b1, WIN_LOCAL});
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      frame(1'b1, 1'b1);
      pulses += int'(last_v);
    end
    check("hold_single", {pulses != 0, wc_a}, {1'b0, WIN_LOCAL});
    restart();
    check("hold_cleared", {wv_a, wc_a}, {1'b0, WIN_NONE});

    // Randomised traffic against the reference
    for (int i = 0; i < 6000; i++) begin
      drive(($urandom_range(999) == 0), ($urandom_range(249) == 0),
            ($urandom_range(299) == 0) ? 2'b00 : 2'b01,
            ($urandom_range(3) == 0), ($urandom_range(29) == 0), ($urandom_range(29) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/winner_judge.md
Name: winner_judge

Overview:
- Sits directly upstream of the game state machine.
- Turns per-player collision flags (local bird, remote bird) into the single-cycle winner_valid pulse and the 2-bit winner_code that the FSM latches on entering GAMEOVER.
- Evaluates on frame boundaries. Applies spawn immunity after each game reset, plus a grace window so near-simultaneous deaths are scored as a draw.

Parameters:
- SPAWN_FRAMES, 60, frames after game_rst during which hits are ignored (0 = no immunity)
- GRACE_FRAMES, 3, frames after the first death during which a second death still yields a draw (0 = decide on the first death's frame)
- CNT_W, 8, width of the frame counters; must hold max(SPAWN_FRAMES, GRACE_FRAMES)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- game_rst  in  1  one-cycle pulse from the game FSM; restarts judging
- state  in  2  game FSM state (00 START, 01 GAME, 10 GAMEOVER)
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- local_hit  in  1  local bird collision/out-of-bounds, level or pulse
- remote_hit  in  1  remote bird collision, level or pulse
- winner_valid  out  1  one-cycle pulse: result decided
- winner_code  out  2  00 none, 01 local wins, 10 remote wins, 11 draw; held after decision

Behaviour:
- Reset: on rst=1 at a clock edge, all of the following clear:
  - FSM to IDLE, both counters to 0, sticky dead flags to 0
  - winner_valid=0, winner_code=00
- game_rst: has the same effect as rst, except the FSM goes to SPAWN, and the spawn counter loads SPAWN_FRAMES (or the FSM goes to ARMED if SPAWN_FRAMES=0). game_rst overrides every other event in the same cycle.
- Sticky flags:
  - local_dead / remote_dead set on a hit input only in ARMED or GRACE, and only while state==01.
  - "Eff" value = sticky flag OR the current-cycle input, so a hit coinciding with frame_tick counts in that frame.
- FSM states and transitions:
  - IDLE: waits for game_rst; ignores hits and ticks.
  - SPAWN: on each frame_tick, decrement the spawn counter; when a tick arrives with counter==1, go to ARMED. Hits are ignored.
  - ARMED: on frame_tick:
    - both eff dead → REPORT with code 11
    - exactly one eff dead and GRACE_FRAMES=0 → REPORT with the survivor's code
    - exactly one eff dead otherwise → GRACE, grace counter=GRACE_FRAMES
    - no deaths → stay
  - GRACE: the second death is checked on every frame_tick, before the counter decrement.
    - both eff dead → REPORT with code 11
    - else decrement; when a tick arrives with counter==1 → REPORT with the survivor's code (local alive → 01, remote alive → 10)
  - REPORT: entered for exactly one cycle.
    - winner_valid=1 in that cycle; winner_code is loaded on the same edge and is valid in that cycle.
    - Next cycle → DONE.
  - DONE: winner_valid=0, winner_code held; leaves only on game_rst or rst.
- Latency: winner_valid is registered and asserts on the cycle after the deciding frame_tick edge.
- Safety: if state!=01 while in SPAWN, ARMED or GRACE → return to IDLE, no pulse, code stays 00. This covers an FSM reset mid-game.
- winner_valid never pulses more than once between two game_rst pulses.
- frame_tick asserted for more than one cycle counts once per cycle; the source guarantees single-cycle pulses.

Decomposition:
- Shared game package:
  - state encoding enum (START/GAME/GAMEOVER), reused from the game FSM
  - winner code constants: WIN_NONE=00, WIN_LOCAL=01, WIN_REMOTE=10, WIN_DRAW=11
- Judge FSM enum stays local to the module.
- One natural sub-module, frame_downcounter: loadable CNT_W counter decremented on frame_tick, with an expire flag on the tick at count 1. Instantiated twice, for spawn and grace.

Test Plan:
- Spawn immunity: rst, state=01, game_rst, local_hit held for 59 ticks, released before tick 60 → no winner_valid; after tick 60 then one more tick with local_hit=1 → enters GRACE; 3 ticks later winner_valid pulse with code 10.
- Draw in grace: ARMED, local_hit pulse at tick N, remote_hit pulse between ticks N+1 and N+2 → winner_valid one cycle after tick N+2, code 11.
- Simultaneous hit: ARMED, local_hit and remote_hit both asserted on the frame_tick cycle → winner_valid next cycle, code 11, no GRACE entry.
- GRACE_FRAMES=0 build: remote_hit in ARMED → pulse on the next tick+1 cycle, code 01.
- Abort: in GRACE, state driven to 00 → return to IDLE, no pulse ever, code 00; game_rst coinciding with a deciding frame_tick → no pulse, SPAWN entered.
- Hold and single-pulse: after a report, keep both hits high for 200 ticks → winner_valid stays 0, winner_code unchanged until game_rst clears it to 00.
